// File: rtl/sram_bus_arbiter_if.sv
// Pipeline-side and bus-side signals of the SRAM port arbiter.
// The arbiter takes the slave modport; the surrounding pipeline, bridge or bench takes master.
interface sram_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ice;
    logic [ADDR_W-1:0] iaddr;
    logic              if_data_ok;
    logic [DATA_W-1:0] inst;
    logic              flush;
    logic              dce;
    logic [3:0]        dwe;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] din;
    logic              mem_data_ok;
    logic [DATA_W-1:0] dout;
    logic              bus_req;
    logic              bus_wr;
    logic [3:0]        bus_wstrb;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_addr_ok;
    logic              bus_data_ok;
    logic [DATA_W-1:0] bus_rdata;

    modport slave (
        input  ice, iaddr, flush, dce, dwe, daddr, din,
        input  bus_addr_ok, bus_data_ok, bus_rdata,
        output if_data_ok, inst, mem_data_ok, dout,
        output bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata
    );

    modport master (
        output ice, iaddr, flush, dce, dwe, daddr, din,
        output bus_addr_ok, bus_data_ok, bus_rdata,
        input  if_data_ok, inst, mem_data_ok, dout,
        input  bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata
    );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like bus port between instruction fetch and data access, data first,
// one transaction in flight; a flush cancels or silently discards the pending fetch.
module sram_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               cpu_clk_50M,
    input  logic               cpu_rst_n,
    sram_bus_arbiter_if.slave  arb
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        IREQ  = 3'd1,
        IWAIT = 3'd2,
        DREQ  = 3'd3,
        DWAIT = 3'd4
    } state_t;

    state_t            state_q;
    logic              drop_q;
    logic              bus_req_q;
    logic              bus_wr_q;
    logic [3:0]        bus_wstrb_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [DATA_W-1:0] bus_wdata_q;
    logic              if_ok_q;
    logic              mem_ok_q;
    logic [DATA_W-1:0] inst_q;
    logic [DATA_W-1:0] dout_q;

    // A requester is blind while its own ok pulse is out (its request line is still high).
    logic d_take, i_take;
    assign d_take = arb.dce & ~mem_ok_q;
    assign i_take = arb.ice & ~if_ok_q & ~arb.flush;

    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n) begin
            state_q     <= IDLE;
            drop_q      <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_wr_q    <= 1'b0;
            bus_wstrb_q <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_ok_q     <= 1'b0;
            mem_ok_q    <= 1'b0;
            inst_q      <= '0;
            dout_q      <= '0;
        end else begin
            if_ok_q  <= 1'b0;
            mem_ok_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (d_take) begin
                        state_q     <= DREQ;
                        bus_req_q   <= 1'b1;
                        bus_wr_q    <= |arb.dwe;
                        bus_wstrb_q <= arb.dwe;
                        bus_addr_q  <= arb.daddr;
                        bus_wdata_q <= arb.din;
                    end else if (i_take) begin
                        state_q     <= IREQ;
                        bus_req_q   <= 1'b1;
                        bus_wr_q    <= 1'b0;
                        bus_wstrb_q <= '0;
                        bus_addr_q  <= arb.iaddr;
                    end
                end
                IREQ: begin
                    if (arb.bus_addr_ok) begin
                        state_q   <= IWAIT;
                        bus_req_q <= 1'b0;
                        drop_q    <= arb.flush;
                    end else if (arb.flush) begin
                        state_q   <= IDLE;
                        bus_req_q <= 1'b0;
                    end
                end
                IWAIT: begin
                    // A flush landing in the same cycle as the response also kills it.
                    if (arb.bus_data_ok) begin
                        state_q <= IDLE;
                        drop_q  <= 1'b0;
                        if (!drop_q && !arb.flush) begin
                            if_ok_q <= 1'b1;
                            inst_q  <= arb.bus_rdata;
                        end
                    end else if (arb.flush) begin
                        drop_q <= 1'b1;
                    end
                end
                DREQ: begin
                    if (arb.bus_addr_ok) begin
                        state_q   <= DWAIT;
                        bus_req_q <= 1'b0;
                    end
                end
                DWAIT: begin
                    if (arb.bus_data_ok) begin
                        state_q  <= IDLE;
                        mem_ok_q <= 1'b1;
                        if (!bus_wr_q) begin
                            dout_q <= arb.bus_rdata;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign arb.bus_req     = bus_req_q;
    assign arb.bus_wr      = bus_wr_q;
    assign arb.bus_wstrb   = bus_wstrb_q;
    assign arb.bus_addr    = bus_addr_q;
    assign arb.bus_wdata   = bus_wdata_q;
    assign arb.if_data_ok  = if_ok_q;
    assign arb.mem_data_ok = mem_ok_q;
    assign arb.inst        = inst_q;
    assign arb.dout        = dout_q;
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed vector table for the SRAM bus arbiter plus a hand-written reset-in-DWAIT sequence.
module tb_sram_bus_arbiter;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    sram_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rst_n),
        .arb         (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ice;
        logic [31:0] iaddr;
        logic        dce;
        logic [3:0]  dwe;
        logic [31:0] daddr;
        logic [31:0] din;
        logic        flush;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic [135:0] exp;
    } vec_t;

    localparam int NV = 34;
    vec_t vecs[NV];

    localparam logic [31:0] I0 = 32'hBFC00000;
    localparam logic [31:0] I1 = 32'hBFC00004;
    localparam logic [31:0] FA = 32'hBFC00100;
    localparam logic [31:0] FB = 32'hBFC00380;
    localparam logic [31:0] FC = 32'hBFC00384;
    localparam logic [31:0] WA = 32'h80000010;
    localparam logic [31:0] WD = 32'h12345678;
    localparam logic [31:0] LA = 32'h80000020;
    localparam logic [31:0] LD = 32'hCAFEF00D;
    localparam logic [31:0] N1 = 32'h3C080001;
    localparam logic [31:0] N2 = 32'h27BDFFE0;
    localparam logic [31:0] N3 = 32'h40806000;
    localparam logic [31:0] RD = 32'h5A5AA5A5;

    // Expected output word: {req, wr, wstrb, addr, wdata, if_ok, mem_ok, inst, dout}
    function automatic vec_t mk(
        input logic ice, input logic [31:0] iaddr, input logic dce, input logic [3:0] dwe,
        input logic [31:0] daddr, input logic [31:0] din, input logic flush,
        input logic aok, input logic dok, input logic [31:0] rdata,
        input logic req, input logic wr, input logic [3:0] strb, input logic [31:0] addr,
        input logic [31:0] wdata, input logic ifok, input logic memok,
        input logic [31:0] inst, input logic [31:0] dout);
        vec_t v;
        v.ice = ice; v.iaddr = iaddr; v.dce = dce; v.dwe = dwe; v.daddr = daddr;
        v.din = din; v.flush = flush; v.aok = aok; v.dok = dok; v.rdata = rdata;
        v.exp = {req, wr, strb, addr, wdata, ifok, memok, inst, dout};
        return v;
    endfunction

    function automatic logic [135:0] outs();
        return {bus_if.bus_req, bus_if.bus_wr, bus_if.bus_wstrb, bus_if.bus_addr,
                bus_if.bus_wdata, bus_if.if_data_ok, bus_if.mem_data_ok,
                bus_if.inst, bus_if.dout};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        bus_if.ice = v.ice;   bus_if.iaddr = v.iaddr;
        bus_if.dce = v.dce;   bus_if.dwe = v.dwe;   bus_if.daddr = v.daddr; bus_if.din = v.din;
        bus_if.flush = v.flush;
        bus_if.bus_addr_ok = v.aok; bus_if.bus_data_ok = v.dok; bus_if.bus_rdata = v.rdata;
    endtask

    initial begin
        // Single fetch
        vecs[0]  = mk(1,I0,0,0,0,0,0,0,0,0,   0,0,0,0, 0,0,0,0,0);
        vecs[1]  = mk(1,I0,0,0,0,0,0,1,0,0,   1,0,0,I0,0,0,0,0,0);
        vecs[2]  = mk(1,I0,0,0,0,0,0,0,1,N1,  0,0,0,I0,0,0,0,0,0);
        vecs[3]  = mk(1,I0,0,0,0,0,0,0,0,0,   0,0,0,I0,0,1,0,N1,0);
        // Simultaneous requests: write wins, fetch follows
        vecs[4]  = mk(1,I1,1,4'hF,WA,WD,0,0,0,0,            0,0,0,   I0,0, 0,0,N1,0);
        vecs[5]  = mk(1,I1,1,4'hF,WA,WD,0,1,0,0,            1,1,4'hF,WA,WD,0,0,N1,0);
        vecs[6]  = mk(1,I1,1,4'hF,WA,WD,0,0,1,32'hAAAA5555, 0,1,4'hF,WA,WD,0,0,N1,0);
        vecs[7]  = mk(1,I1,1,4'hF,WA,WD,0,0,0,0,            0,1,4'hF,WA,WD,0,1,N1,0);
        vecs[8]  = mk(1,I1,0,0,0,0,0,1,0,0,   1,0,0,I1,WD,0,0,N1,0);
        vecs[9]  = mk(1,I1,0,0,0,0,0,0,1,N2,  0,0,0,I1,WD,0,0,N1,0);
        vecs[10] = mk(0,0, 0,0,0,0,0,0,0,0,   0,0,0,I1,WD,1,0,N2,0);
        // Flush before accept
        vecs[11] = mk(1,FA,0,0,0,0,0,0,0,0,   0,0,0,I1,WD,0,0,N2,0);
        vecs[12] = mk(1,FA,0,0,0,0,1,0,0,0,   1,0,0,FA,WD,0,0,N2,0);
        vecs[13] = mk(1,FB,0,0,0,0,0,0,0,0,   0,0,0,FA,WD,0,0,N2,0);
        vecs[14] = mk(1,FB,0,0,0,0,0,1,0,0,   1,0,0,FB,WD,0,0,N2,0);
        vecs[15] = mk(1,FB,0,0,0,0,0,0,1,N3,  0,0,0,FB,WD,0,0,N2,0);
        vecs[16] = mk(0,0, 0,0,0,0,0,0,0,0,   0,0,0,FB,WD,1,0,N3,0);
        // Flush after accept, late response discarded, then a stray data_ok in IDLE
        vecs[17] = mk(1,FC,0,0,0,0,0,0,0,0,   0,0,0,FB,WD,0,0,N3,0);
        vecs[18] = mk(1,FC,0,0,0,0,0,1,0,0,   1,0,0,FC,WD,0,0,N3,0);
        vecs[19] = mk(0,0, 0,0,0,0,1,0,0,0,   0,0,0,FC,WD,0,0,N3,0);
        vecs[20] = mk(0,0, 0,0,0,0,0,0,0,0,   0,0,0,FC,WD,0,0,N3,0);
        vecs[21] = mk(0,0, 0,0,0,0,0,0,0,0,   0,0,0,FC,WD,0,0,N3,0);
        vecs[22] = mk(0,0, 0,0,0,0,0,0,1,32'hDEADBEEF, 0,0,0,FC,WD,0,0,N3,0);
        vecs[23] = mk(0,0, 0,0,0,0,0,0,1,32'h11111111, 0,0,0,FC,WD,0,0,N3,0);
        // Load with addr_ok stalled 2 cycles and data_ok stalled 3 cycles
        vecs[24] = mk(0,0,1,0,LA,LD,0,0,0,0,   0,0,0,FC,WD,0,0,N3,0);
        vecs[25] = mk(0,0,1,0,LA,LD,0,0,0,0,   1,0,0,LA,LD,0,0,N3,0);
        vecs[26] = mk(0,0,1,0,LA,LD,0,0,0,0,   1,0,0,LA,LD,0,0,N3,0);
        vecs[27] = mk(0,0,1,0,LA,LD,0,1,0,0,   1,0,0,LA,LD,0,0,N3,0);
        vecs[28] = mk(0,0,1,0,LA,LD,0,0,0,0,   0,0,0,LA,LD,0,0,N3,0);
        vecs[29] = mk(0,0,1,0,LA,LD,1,0,0,0,   0,0,0,LA,LD,0,0,N3,0);
        vecs[30] = mk(0,0,1,0,LA,LD,0,0,0,0,   0,0,0,LA,LD,0,0,N3,0);
        vecs[31] = mk(0,0,1,0,LA,LD,0,0,1,RD,  0,0,0,LA,LD,0,0,N3,0);
        vecs[32] = mk(0,0,1,0,LA,LD,0,0,0,0,   0,0,0,LA,LD,0,1,N3,RD);
        vecs[33] = mk(0,0,0,0,0,0,0,0,0,0,     0,0,0,LA,LD,0,0,N3,RD);

        rst_n = 1'b0;
        apply(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
        step();
        step();
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
            $display("vec %0d: ice=%b dce=%b flush=%b aok=%b dok=%b out=%h",
                     i, vecs[i].ice, vecs[i].dce, vecs[i].flush, vecs[i].aok, vecs[i].dok, outs());
            apply(vecs[i]);
            step();
        end

        // Reset while a write waits in DWAIT; the late response must be ignored.
        bus_if.dce = 1'b1; bus_if.dwe = 4'b0011;
        bus_if.daddr = 32'h80000040; bus_if.din = 32'h0000BEEF;
        step();
        check32("rst_seq_req", {29'd0, bus_if.bus_req, bus_if.bus_wr, bus_if.bus_wstrb == 4'b0011}, 32'd7);
        bus_if.bus_addr_ok = 1'b1;
        step();
        check32("rst_seq_dwait", {31'd0, bus_if.bus_req}, 32'd0);
        bus_if.bus_addr_ok = 1'b0;
        bus_if.dce = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus_if.bus_data_ok = 1'b1;
        bus_if.bus_rdata = 32'hFFFFFFFF;
        check("rst_outputs", outs(), 136'd0);
        $display("reset in DWAIT: out=%h", outs());
        step();
        bus_if.bus_data_ok = 1'b0;
        check("rst_late_dok", outs(), 136'd0);
        step();
        check("rst_quiet", outs(), 136'd0);

        // Arbiter must be back in IDLE: a fresh fetch raises bus_req on the next edge.
        bus_if.ice = 1'b1; bus_if.iaddr = I0;
        begin
            int n;
            n = 0;
            while (bus_if.bus_req !== 1'b1 && n < 5) begin
                step();
                n++;
            end
            check32("rst_refetch_latency", n, 1);
        end
        check32("rst_refetch_addr", bus_if.bus_addr, I0);
        bus_if.bus_addr_ok = 1'b1;
        step();
        bus_if.bus_addr_ok = 1'b0;
        bus_if.bus_data_ok = 1'b1;
        bus_if.bus_rdata = N2;
        step();
        bus_if.bus_data_ok = 1'b0;
        begin
            int n;
            n = 0;
            while (bus_if.if_data_ok !== 1'b1 && n < 5) begin
                check32("no_mem_ok", {31'd0, bus_if.mem_data_ok}, 32'd0);
                step();
                n++;
            end
            check32("rst_refetch_ok_wait", n, 0);
        end
        check32("rst_refetch_inst", bus_if.inst, N2);
        $display("refetch after reset: inst=%h", bus_if.inst);
        bus_if.ice = 1'b0;
        step();
        check32("ok_pulse_width", {31'd0, bus_if.if_data_ok}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
